// File: rtl/volt_monitor_emu.sv
// -----------------------------------------------------------------------------
// volt_monitor_emu
//
// Emulates the power board's multiplexed voltage comparators for the
// hardware-in-the-loop rig. The power manager scans channels with `sel` and
// reads one comparator bit back on `data`. Faults can be forced statically per
// channel or scheduled after a programmable delay. The block also measures how
// many cycles the power manager takes to drop `kill_sw` once a scheduled fault
// goes live.
//
// Parameters
//   SETTLE_CYCLES  cycles the mux output holds after a settled channel change
//   LAT_W          width of the trip-latency counter
//
// Ports
//   clk           system clock (50 MHz)
//   reset_n       synchronous, active-low reset
//   sel           channel select from the power manager (asynchronous)
//   kill_sw       power enable from the power manager, 1 = power on
//   fault_force   static fault per channel 0..6, bit c inverts channel c
//   fault_arm     one-cycle pulse, arms the scheduled fault
//   fault_chan    scheduled fault channel, 7 = no channel
//   fault_delay   cycles from arm to fault activation
//   fault_clear   one-cycle pulse, returns the scheduler to IDLE
//   data          emulated comparator output (registered)
//   armed         high while the scheduled fault is counting down
//   trip_valid    high once a trip has been recorded
//   trip_latency  cycles from fault activation to the kill_sw fall
// -----------------------------------------------------------------------------
module volt_monitor_emu #(
  parameter int SETTLE_CYCLES = 8,
  parameter int LAT_W         = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       sel,
  input  logic             kill_sw,
  input  logic [6:0]       fault_force,
  input  logic             fault_arm,
  input  logic [2:0]       fault_chan,
  input  logic [15:0]      fault_delay,
  input  logic             fault_clear,
  output logic             data,
  output logic             armed,
  output logic             trip_valid,
  output logic [LAT_W-1:0] trip_latency
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    TRIPPED
  } state_t;

  // +2 keeps the width at least one bit and leaves room for the load value
  localparam int               SC_W        = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES);
  localparam logic [2:0]       CHAN_IDLE   = 3'd7;

  // select path
  logic [2:0]      sel_meta;
  logic [2:0]      sel_s;
  logic [2:0]      chan_settled;
  logic [2:0]      settle_target;
  logic [SC_W-1:0] settle_cnt;
  logic            settling;
  logic            sel_moved;

  // scheduler
  state_t          state_q;
  state_t          state_d;
  logic [2:0]      fault_chan_q;
  logic [15:0]     dly_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic            arm_accept;
  logic            kill_q;
  logic            kill_prev;
  logic            kill_fall;

  // fault evaluation
  logic [7:0]      force_ext;
  logic            sched_hit;
  logic            healthy;
  logic            faulty;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous channel select.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_meta <= CHAN_IDLE;
      sel_s    <= CHAN_IDLE;
    end else begin
      sel_meta <= sel;
      sel_s    <= sel_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Settle timer. A change is compared against the value currently being
  // settled (or the settled channel when idle), so a second change during
  // settling restarts the wait and only the final selection is adopted.
  // The new channel is adopted on the same edge the counter reaches zero.
  // ---------------------------------------------------------------------------
  assign settling  = (settle_cnt != '0);
  assign sel_moved = settling ? (sel_s != settle_target) : (sel_s != chan_settled);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      settle_cnt    <= '0;
      settle_target <= CHAN_IDLE;
      chan_settled  <= CHAN_IDLE;
    end else if (sel_moved) begin
      if (SETTLE_CYCLES == 0) begin
        chan_settled <= sel_s;
      end else begin
        settle_cnt    <= SETTLE_LOAD;
        settle_target <= sel_s;
      end
    end else if (settling) begin
      settle_cnt <= settle_cnt - 1'b1;
      if (settle_cnt == SC_W'(1)) begin
        chan_settled <= settle_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // kill_sw is registered twice so a 1->0 edge can be detected cleanly.
  // Both flops reset low so no spurious fall appears after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kill_q    <= 1'b0;
      kill_prev <= 1'b0;
    end else begin
      kill_q    <= kill_sw;
      kill_prev <= kill_q;
    end
  end

  assign kill_fall = kill_prev & ~kill_q;

  // ---------------------------------------------------------------------------
  // Scheduler next-state logic. Clear overrides everything, including an arm
  // in the same cycle. A zero delay skips ARMED entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fault_arm) begin
          state_d = (fault_delay == 16'd0) ? ACTIVE : ARMED;
        end
      end
      ARMED: begin
        if (dly_cnt <= 16'd1) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (kill_fall) begin
          state_d = TRIPPED;
        end
      end
      TRIPPED: begin
        state_d = TRIPPED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (fault_clear) begin
      state_d = IDLE;
    end
  end

  assign arm_accept = (state_q == IDLE) && fault_arm && !fault_clear;

  // ---------------------------------------------------------------------------
  // Scheduler registers: state, latched fault channel, delay countdown,
  // latency counter and the captured trip latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fault_chan_q <= CHAN_IDLE;
      dly_cnt      <= '0;
      lat_cnt      <= '0;
      trip_latency <= '0;
    end else begin
      state_q <= state_d;

      if (arm_accept) begin
        fault_chan_q <= fault_chan;
        dly_cnt      <= fault_delay;
      end else if ((state_q == ARMED) && (dly_cnt != 16'd0)) begin
        dly_cnt <= dly_cnt - 16'd1;
      end

      // latency restarts at zero on ACTIVE entry and saturates at all-ones
      if ((state_d == ACTIVE) && (state_q != ACTIVE)) begin
        lat_cnt <= '0;
      end else if ((state_q == ACTIVE) && (lat_cnt != '1)) begin
        lat_cnt <= lat_cnt + 1'b1;
      end

      if ((state_q == ACTIVE) && (state_d == TRIPPED)) begin
        trip_latency <= lat_cnt;
      end
    end
  end

  assign armed      = (state_q == ARMED);
  assign trip_valid = (state_q == TRIPPED);

  // ---------------------------------------------------------------------------
  // Comparator output. Even channels are undervoltage (healthy 1), odd are
  // overvoltage (healthy 0); the idle channel 7 reads 0 with no faults.
  // ---------------------------------------------------------------------------
  assign force_ext = {1'b0, fault_force};
  assign sched_hit = ((state_q == ACTIVE) || (state_q == TRIPPED)) &&
                     (chan_settled == fault_chan_q) &&
                     (chan_settled != CHAN_IDLE);
  assign healthy   = (chan_settled != CHAN_IDLE) & ~chan_settled[0];
  assign faulty    = force_ext[chan_settled] | sched_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= 1'b0;
    end else begin
      data <= healthy ^ faulty;
    end
  end

endmodule
